pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RV64 core.
- Generalises the one-cycle branch control stall into a registered FSM.
- Arbitrates three stall sources: load-use hazards, branch resolution and the multi-cycle multiply/divide unit (MDU).
- Drives every per-stage stall/flush enable for the PC, IF_ID, ID_EX and EX_MEM registers.

Parameters:
- REG_ADDR_W, 5, register index width.
- MDU_MAX_CYC, 64, MDU watchdog limit in cycles (≥2).
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- branch  in  2  ID-stage branch/jump class; nonzero means a control-transfer instruction is in ID.
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID.
- ex_rd  in  REG_ADDR_W  destination register of the instruction in EX.
- ex_memread  in  1  the instruction in EX is a load.
- br_valid  in  1  EX reports the branch outcome this cycle.
- mdu_start  in  1  one-cycle pulse: an MDU operation entered EX.
- mdu_done  in  1  one-cycle pulse: MDU result is ready.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold IF_ID.
- if_id_flush  out  1  load a bubble into IF_ID.
- id_ex_stall  out  1  hold ID_EX.
- id_ex_flush  out  1  load a bubble into ID_EX.
- ex_mem_flush  out  1  load a bubble into EX_MEM.
- mdu_timeout  out  1  sticky watchdog error.
- busy  out  1  state is not RUN.

Behaviour:
- FSM states: RUN, BR_WAIT, MDU_BUSY. State and counters are registered. Stall/flush outputs are combinational from state plus inputs.
- Reset (asynchronous, mid-operation included):
  - state goes to RUN; watchdog and perf counters clear to 0; mdu_timeout clears to 0.
  - While rst is high, every output reads 0.
- Load-use hazard: lu = ex_memread & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2).
- RUN, priority order:
  1. mdu_start: go to MDU_BUSY. Assert pc_stall, if_id_stall, id_ex_stall and ex_mem_flush in this same cycle.
  2. else lu: pc_stall=1, if_id_stall=1, id_ex_flush=1 for exactly one cycle; stay in RUN. The load advances, so lu deasserts on the next cycle.
  3. else branch != 0: pc_stall=1, if_id_flush=1; the branch advances to EX; go to BR_WAIT.
  4. else: all stall/flush outputs 0.
- Branch and lu in the same cycle: lu wins; the branch is re-evaluated next cycle.
- Branch and mdu_start in the same cycle: MDU wins; the branch is held in IF_ID and re-seen on return to RUN.
- BR_WAIT:
  - pc_stall=1 and if_id_flush=1 every cycle until br_valid.
  - In the br_valid cycle: pc_stall=0 so the datapath loads the target or PC+4, if_id_flush=1; next state RUN.
  - br_valid in RUN is ignored.
  - mdu_start in BR_WAIT is illegal (flagged by an assertion) and ignored.
- MDU_BUSY:
  - pc_stall, if_id_stall, id_ex_stall and ex_mem_flush are all held at 1.
  - The watchdog counter increments each cycle.
  - mdu_done: deassert all outputs in that cycle, clear the counter, go to RUN.
  - Counter reaches MDU_MAX_CYC-1 without mdu_done: set mdu_timeout (sticky until reset), clear the counter, go to RUN.
  - mdu_done in the same cycle as the limit: treated as done; mdu_timeout is not set.
- The counter never wraps; it is cleared on every exit from MDU_BUSY.
- busy = (state != RUN).

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- With the macro defined, three additional ports are added, each `out CNT_W`: perf_lu_cnt, perf_br_cnt, perf_mdu_cnt.
  - perf_lu_cnt counts load-use bubble cycles.
  - perf_br_cnt counts BR_WAIT cycles plus branch-entry cycles.
  - perf_mdu_cnt counts MDU_BUSY cycles plus MDU-entry cycles.
  - All three saturate at all-ones and reset to 0.
- Without the macro: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared header common.vh holds:
  - state encodings PHC_RUN=2'd0, PHC_BR_WAIT=2'd1, PHC_MDU_BUSY=2'd2;
  - the BRANCH_NONE=2'b00 constant;
  - the default for MDU_MAX_CYC.
- One natural sub-module, pipe_hazard_lu_detect: the combinational load-use comparator, reusable by the forwarding unit.
- FSM, watchdog and performance counters stay in pipe_hazard_ctrl.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs2=5 → one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1; next cycle all 0. Repeat with ex_rd=0 → no stall.
- Branch: branch=2'b01 at cycle 0, br_valid at cycle 3 → pc_stall=1 for cycles 0–2 and 0 at cycle 3; if_id_flush=1 for cycles 0–3; busy=1 for cycles 1–3; RUN at cycle 4.
- MDU: mdu_start at cycle 0, mdu_done at cycle 10 → stall set held for cycles 0–9, deasserted at cycle 10; mdu_timeout=0.
- Watchdog: MDU_MAX_CYC=8, mdu_start with no mdu_done → mdu_timeout=1 after 8 cycles, state RUN, flag stays 1 until rst.
- Simultaneous events:
  - branch=2'b10 together with mdu_start → MDU_BUSY first; after mdu_done, branch handling enters BR_WAIT.
  - branch together with lu → lu bubble, then BR_WAIT.
- Reset mid-operation: rst pulsed in BR_WAIT and in MDU_BUSY → outputs 0 immediately (asynchronously); after release, state RUN; with PIPE_HAZARD_PERF_EN defined, all perf counters read 0.

Source files
------------

// File: rtl/pipe_hazard_pkg.sv
// ============================================================================
// Module  : pipe_hazard_pkg
// Brief   : Shared state encodings and constants for the pipeline sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipe_hazard_pkg;

  typedef enum logic [1:0] {
    PHC_RUN      = 2'd0,
    PHC_BR_WAIT  = 2'd1,
    PHC_MDU_BUSY = 2'd2
  } phc_state_e;

  localparam logic [1:0] BRANCH_NONE     = 2'b00;
  localparam int         MDU_MAX_CYC_DEF = 64;

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_lu_detect.sv
// ============================================================================
// Module  : pipe_hazard_lu_detect
// Brief   : Combinational load-use comparator, shared with the forwarding unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_lu_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  output logic                  lu
);

  // x0 is hardwired zero, so a load into it never creates a dependency.
  assign lu = ex_memread && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module  : pipe_hazard_ctrl
// Brief   : Pipeline stall/flush sequencer (load-use, branch, MDU + watchdog).
//           Optional perf counters enabled by macro PIPE_HAZARD_PERF_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MDU_MAX_CYC = MDU_MAX_CYC_DEF,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            branch,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_memread,
  input  logic                  br_valid,
  input  logic                  mdu_start,
  input  logic                  mdu_done,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_stall,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic                  mdu_timeout,
  output logic                  busy
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]      perf_lu_cnt,
  output logic [CNT_W-1:0]      perf_br_cnt,
  output logic [CNT_W-1:0]      perf_mdu_cnt
`endif
);

  localparam int WD_W = (MDU_MAX_CYC > 2) ? $clog2(MDU_MAX_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MDU_MAX_CYC - 1);

  phc_state_e      state, state_nxt;
  logic [WD_W-1:0] wd_cnt;
  logic            lu;
  logic            timeout_set;
  logic            to_flag;

  pipe_hazard_lu_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_lu_detect (
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .lu         (lu)
  );

  always_comb begin
    state_nxt    = state;
    timeout_set  = 1'b0;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    case (state)
      PHC_RUN: begin
        if (mdu_start) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_flush = 1'b1;
          state_nxt    = PHC_MDU_BUSY;
        end else if (lu) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end else if (branch != BRANCH_NONE) begin
          pc_stall    = 1'b1;
          if_id_flush = 1'b1;
          state_nxt   = PHC_BR_WAIT;
        end
      end
      PHC_BR_WAIT: begin
        // Releasing the PC in the resolve cycle lets it load target or PC+4.
        if_id_flush = 1'b1;
        if (br_valid) state_nxt = PHC_RUN;
        else          pc_stall  = 1'b1;
      end
      PHC_MDU_BUSY: begin
        if (mdu_done) begin
          state_nxt = PHC_RUN;
        end else begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_flush = 1'b1;
          if (wd_cnt == WD_LIMIT) begin
            timeout_set = 1'b1;
            state_nxt   = PHC_RUN;
          end
        end
      end
      default: state_nxt = PHC_RUN;
    endcase
    if (rst) begin
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_stall  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= PHC_RUN;
      wd_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == PHC_MDU_BUSY && state_nxt == PHC_MDU_BUSY) wd_cnt <= wd_cnt + WD_W'(1);
      else                                                      wd_cnt <= '0;
      if (timeout_set) to_flag <= 1'b1;
    end
  end

  assign mdu_timeout = to_flag && !rst;
  assign busy        = (state != PHC_RUN) && !rst;

`ifdef PIPE_HAZARD_PERF_EN
  logic lu_ev, br_ev, mdu_ev;

  assign lu_ev  = (state == PHC_RUN) && !mdu_start && lu;
  assign br_ev  = (state == PHC_BR_WAIT) ||
                  ((state == PHC_RUN) && !mdu_start && !lu && (branch != BRANCH_NONE));
  assign mdu_ev = (state == PHC_MDU_BUSY) || ((state == PHC_RUN) && mdu_start);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lu_cnt  <= '0;
      perf_br_cnt  <= '0;
      perf_mdu_cnt <= '0;
    end else begin
      if (lu_ev  && perf_lu_cnt  != '1) perf_lu_cnt  <= perf_lu_cnt  + CNT_W'(1);
      if (br_ev  && perf_br_cnt  != '1) perf_br_cnt  <= perf_br_cnt  + CNT_W'(1);
      if (mdu_ev && perf_mdu_cnt != '1) perf_mdu_cnt <= perf_mdu_cnt + CNT_W'(1);
    end
  end
`endif

`ifndef SYNTHESIS
  a_no_mdu_in_br : assert property (@(posedge clk) disable iff (rst)
                                    !(state == PHC_BR_WAIT && mdu_start));
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module  : tb_pipe_hazard_ctrl
// Brief   : Scoreboard bench: driver queues per-cycle expected outputs, monitor checks.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

  localparam logic [7:0] PC  = 8'h01, IFS = 8'h02, IFF = 8'h04, IXS = 8'h08;
  localparam logic [7:0] IXF = 8'h10, EMF = 8'h20, TO  = 8'h40, BSY = 8'h80;
  localparam logic [7:0] MST = PC | IFS | IXS | EMF;

  typedef struct {
    string      name;
    logic [7:0] exp;
    bit         sel;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] branch = '0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       ex_memread = 1'b0, br_valid = 1'b0, mdu_start = 1'b0, mdu_done = 1'b0;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic       ex_mem_flush, mdu_timeout, busy;

  logic       wd_rst = 1'b1, wd_mdu_start = 1'b0, wd_mdu_done = 1'b0;
  logic       w_pc, w_ifs, w_iff, w_ixs, w_ixf, w_emf, w_to, w_busy;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_lu_cnt, perf_br_cnt, perf_mdu_cnt;
  logic [31:0] wp_lu, wp_br, wp_mdu;
`endif

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .MDU_MAX_CYC(64), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .branch(branch), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .br_valid(br_valid),
    .mdu_start(mdu_start), .mdu_done(mdu_done), .pc_stall(pc_stall),
    .if_id_stall(if_id_stall), .if_id_flush(if_id_flush), .id_ex_stall(id_ex_stall),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .mdu_timeout(mdu_timeout), .busy(busy)
`ifdef PIPE_HAZARD_PERF_EN
    , .perf_lu_cnt(perf_lu_cnt), .perf_br_cnt(perf_br_cnt), .perf_mdu_cnt(perf_mdu_cnt)
`endif
  );

  // Second instance with a short watchdog limit.
  pipe_hazard_ctrl #(.REG_ADDR_W(5), .MDU_MAX_CYC(8), .CNT_W(32)) wdut (
    .clk(clk), .rst(wd_rst), .branch(2'b00), .id_rs1(5'd0), .id_rs2(5'd0),
    .ex_rd(5'd0), .ex_memread(1'b0), .br_valid(1'b0),
    .mdu_start(wd_mdu_start), .mdu_done(wd_mdu_done), .pc_stall(w_pc),
    .if_id_stall(w_ifs), .if_id_flush(w_iff), .id_ex_stall(w_ixs),
    .id_ex_flush(w_ixf), .ex_mem_flush(w_emf), .mdu_timeout(w_to), .busy(w_busy)
`ifdef PIPE_HAZARD_PERF_EN
    , .perf_lu_cnt(wp_lu), .perf_br_cnt(wp_br), .perf_mdu_cnt(wp_mdu)
`endif
  );

  logic [7:0] act_a, act_b;
  assign act_a = {busy, mdu_timeout, ex_mem_flush, id_ex_flush, id_ex_stall,
                  if_id_flush, if_id_stall, pc_stall};
  assign act_b = {w_busy, w_to, w_emf, w_ixf, w_ixs, w_iff, w_ifs, w_pc};

  // Monitor: one expected vector per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [7:0] a;
      e = q.pop_front();
      a = e.sel ? act_b : act_a;
      checks++;
      if (a !== e.exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b (busy,to,emf,ixf,ixs,iff,ifs,pc)",
                 e.name, a, e.exp);
      end
    end
  end

  task automatic cyc(input string nm, input logic [7:0] e);
    q.push_back('{nm, e, 1'b0});
    @(posedge clk); #1;
  endtask

  task automatic cycw(input string nm, input logic [7:0] e);
    q.push_back('{nm, e, 1'b1});
    @(posedge clk); #1;
  endtask

  initial begin
    @(posedge clk); #1;
    // Hazard inputs present while in reset: outputs must stay low.
    ex_memread = 1; ex_rd = 5; id_rs2 = 5; branch = 2'b01;
    cyc("rst_gate", 8'h00);
    branch = 0; rst = 0;

    // Load-use
    cyc("lu_rs2", PC | IFS | IXF);
    ex_memread = 0;
    cyc("lu_after", 8'h00);
    ex_memread = 1; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    cyc("lu_x0", 8'h00);
    ex_rd = 7; id_rs1 = 7; id_rs2 = 3;
    cyc("lu_rs1", PC | IFS | IXF);
    ex_memread = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;

    // Branch resolved on cycle 3
    branch = 2'b01;
    cyc("br_c0", PC | IFF);
    branch = 0;
    cyc("br_c1", PC | IFF | BSY);
    cyc("br_c2", PC | IFF | BSY);
    br_valid = 1;
    cyc("br_c3", IFF | BSY);
    cyc("brv_in_run", 8'h00);
    br_valid = 0;

    // MDU done on cycle 10
    mdu_start = 1;
    cyc("mdu_c0", MST);
    mdu_start = 0;
    for (int i = 1; i <= 9; i++) cyc("mdu_hold", MST | BSY);
    mdu_done = 1;
    cyc("mdu_done", BSY);
    mdu_done = 0;
    cyc("mdu_run", 8'h00);

    // Branch with mdu_start: MDU first, branch held and re-seen
    branch = 2'b10; mdu_start = 1;
    cyc("brmdu_c0", MST);
    mdu_start = 0;
    cyc("brmdu_c1", MST | BSY);
    mdu_done = 1;
    cyc("brmdu_done", BSY);
    mdu_done = 0;
    cyc("brmdu_br", PC | IFF);
    branch = 0; br_valid = 1;
    cyc("brmdu_res", IFF | BSY);
    br_valid = 0;
    cyc("brmdu_run", 8'h00);

    // Branch with load-use: bubble first
    branch = 2'b01; ex_memread = 1; ex_rd = 3; id_rs1 = 3;
    cyc("brlu_c0", PC | IFS | IXF);
    ex_memread = 0;
    cyc("brlu_br", PC | IFF);
    branch = 0; br_valid = 1;
    cyc("brlu_res", IFF | BSY);
    br_valid = 0; ex_rd = 0; id_rs1 = 0;
    cyc("brlu_run", 8'h00);

    // Reset in BR_WAIT: a pulse shorter than half a cycle must clear state
    branch = 2'b01;
    cyc("rbr_c0", PC | IFF);
    branch = 0;
    cyc("rbr_c1", PC | IFF | BSY);
    rst = 1; #2; rst = 0;
    cyc("rbr_pulse", 8'h00);
    cyc("rbr_after", 8'h00);

    // Reset in MDU_BUSY
    mdu_start = 1;
    cyc("rmdu_c0", MST);
    mdu_start = 0;
    cyc("rmdu_c1", MST | BSY);
    rst = 1;
    cyc("rmdu_held", 8'h00);
    rst = 0;
    cyc("rmdu_after", 8'h00);
`ifdef PIPE_HAZARD_PERF_EN
    checks++;
    if ({perf_lu_cnt, perf_br_cnt, perf_mdu_cnt} !== 96'd0) begin
      errors++;
      $display("FAIL perf_rst: got %0d/%0d/%0d expected 0/0/0",
               perf_lu_cnt, perf_br_cnt, perf_mdu_cnt);
    end
`endif

    // Watchdog (limit 8): timeout without done
    wd_rst = 0;
    wd_mdu_start = 1;
    cycw("wd_c0", MST);
    wd_mdu_start = 0;
    for (int i = 1; i <= 8; i++) cycw("wd_hold", MST | BSY);
    cycw("wd_timeout", TO);
    cycw("wd_sticky", TO);
    wd_rst = 1;
    cycw("wd_rst", 8'h00);
    wd_rst = 0;
    cycw("wd_cleared", 8'h00);

    // Done on the limit cycle wins over the watchdog
    wd_mdu_start = 1;
    cycw("wdl_c0", MST);
    wd_mdu_start = 0;
    for (int i = 1; i <= 7; i++) cycw("wdl_hold", MST | BSY);
    wd_mdu_done = 1;
    cycw("wdl_done", BSY);
    wd_mdu_done = 0;
    cycw("wdl_no_to", 8'h00);

    @(negedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
